// File: rtl/pipe_pkg.sv
// Shared encodings for the execute stage: ALU opcodes, operand-B sources,
// the multiply sequencer states and the EX/MEM control bundle.
package pipe_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;
  localparam logic [2:0] OP_MUL = 3'b100;

  localparam logic [1:0] SRC_REG  = 2'b00;
  localparam logic [1:0] SRC_IMM  = 2'b01;
  localparam logic [1:0] SRC_UPPR = 2'b10;
  localparam logic [1:0] SRC_REG2 = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } ex_state_t;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } ex_ctl_t;

endpackage

// File: rtl/seq_mul.sv
// Iterative 32x32 shift-add multiplier, one partial product per cycle.
// Holds the IDLE/MUL/DONE sequence; busy is high in MUL, done for one cycle after.
module seq_mul
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_product
);

  ex_state_t   r_state;
  logic [4:0]  r_cnt;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= MUL;
          end
        end
        MUL: begin
          // Multiplicand walks left, multiplier walks right; only the low word is kept.
          if (r_b[0]) r_acc <= r_acc + r_a;
          r_a   <= r_a << 1;
          r_b   <= r_b >> 1;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) r_state <= DONE;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy    = (r_state == MUL);
  assign o_done    = (r_state == DONE);
  assign o_product = r_acc;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, EX/MEM pipeline register and a
// stalling path through seq_mul for MUL.
module ex_stage
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Reg_Write_in,
  input  logic        Mem_Read_in,
  input  logic        Mem_Write_in,
  input  logic        Mem_to_Reg_in,
  input  logic        Reg_Dst_in,
  input  logic [1:0]  ALU_src,
  input  logic [2:0]  ALU_operation,
  input  logic [4:0]  Rs,
  input  logic [4:0]  dst_1,
  input  logic [4:0]  dst_2,
  input  logic [31:0] data_1,
  input  logic [31:0] data_2,
  input  logic [31:0] sh_in,
  input  logic [4:0]  fwd_mem_dst,
  input  logic [4:0]  fwd_wb_dst,
  input  logic        fwd_mem_we,
  input  logic        fwd_wb_we,
  input  logic [31:0] fwd_mem_data,
  input  logic [31:0] fwd_wb_data,
  output logic        ex_busy,
  output logic [31:0] alu_result,
  output logic [31:0] store_data,
  output logic [4:0]  dst_out,
  output logic        Reg_Write_out,
  output logic        Mem_Read_out,
  output logic        Mem_Write_out,
  output logic        Mem_to_Reg_out,
  output logic        zero
);

  logic [31:0] w_fwd_a, w_fwd_b, w_op_b, w_alu;
  logic [4:0]  w_dst;
  logic        w_mul_dec, w_mul_busy, w_mul_done, w_issue;
  logic [31:0] w_product;
  ex_ctl_t     w_ctl;

  ex_ctl_t     r_ctl, r_mul_ctl;
  logic [31:0] r_alu, r_store, r_mul_b;
  logic [4:0]  r_dst, r_mul_dst;
  logic        r_zero;

  // MEM beats WB; register 0 never forwards.
  always_comb begin
    w_fwd_a = data_1;
    if (fwd_mem_we && fwd_mem_dst == Rs && Rs != 5'd0)        w_fwd_a = fwd_mem_data;
    else if (fwd_wb_we && fwd_wb_dst == Rs && Rs != 5'd0)     w_fwd_a = fwd_wb_data;
    w_fwd_b = data_2;
    if (fwd_mem_we && fwd_mem_dst == dst_1 && dst_1 != 5'd0)     w_fwd_b = fwd_mem_data;
    else if (fwd_wb_we && fwd_wb_dst == dst_1 && dst_1 != 5'd0)  w_fwd_b = fwd_wb_data;
  end

  always_comb begin
    case (ALU_src)
      SRC_IMM:  w_op_b = sh_in;
      SRC_UPPR: w_op_b = {sh_in[15:0], 16'b0};
      default:  w_op_b = w_fwd_b;
    endcase
  end

  always_comb begin
    case (ALU_operation)
      OP_AND:  w_alu = w_fwd_a & w_op_b;
      OP_OR:   w_alu = w_fwd_a | w_op_b;
      OP_SUB:  w_alu = w_fwd_a - w_op_b;
      OP_SLT:  w_alu = ($signed(w_fwd_a) < $signed(w_op_b)) ? 32'd1 : 32'd0;
      default: w_alu = w_fwd_a + w_op_b;
    endcase
  end

  assign w_dst     = Reg_Dst_in ? dst_2 : dst_1;
  assign w_ctl     = '{reg_write: Reg_Write_in, mem_read: Mem_Read_in,
                       mem_write: Mem_Write_in, mem_to_reg: Mem_to_Reg_in};
  assign w_mul_dec = (ALU_operation == OP_MUL);
  assign w_issue   = w_mul_dec && !w_mul_busy && !w_mul_done;

  // Gated by rst_n so the hold request drops the moment reset asserts.
  assign ex_busy = rst_n & (w_mul_busy | (w_mul_dec & ~w_mul_done));

  seq_mul u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_issue),
    .i_a       (w_fwd_a),
    .i_b       (w_fwd_b),
    .o_busy    (w_mul_busy),
    .o_done    (w_mul_done),
    .o_product (w_product)
  );

  // Destination and control are captured at issue so later input changes cannot leak in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mul_ctl <= '0;
      r_mul_dst <= '0;
      r_mul_b   <= '0;
    end else if (w_issue) begin
      r_mul_ctl <= w_ctl;
      r_mul_dst <= w_dst;
      r_mul_b   <= w_fwd_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctl   <= '0;
      r_alu   <= '0;
      r_store <= '0;
      r_dst   <= '0;
      r_zero  <= 1'b0;
    end else if (ex_busy) begin
      r_ctl <= '0;
    end else if (w_mul_done) begin
      r_ctl   <= r_mul_ctl;
      r_alu   <= w_product;
      r_store <= r_mul_b;
      r_dst   <= r_mul_dst;
      r_zero  <= (w_product == 32'd0);
    end else begin
      r_ctl   <= w_ctl;
      r_alu   <= w_alu;
      r_store <= w_fwd_b;
      r_dst   <= w_dst;
      r_zero  <= (w_alu == 32'd0);
    end
  end

  assign alu_result     = r_alu;
  assign store_data     = r_store;
  assign dst_out        = r_dst;
  assign zero           = r_zero;
  assign Reg_Write_out  = r_ctl.reg_write;
  assign Mem_Read_out   = r_ctl.mem_read;
  assign Mem_Write_out  = r_ctl.mem_write;
  assign Mem_to_Reg_out = r_ctl.mem_to_reg;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: forwarding, ALU ops, MUL stall/bubble, reset abort.
module tb_ex_stage;
  import pipe_pkg::*;

  logic        clk, rst_n;
  logic        Reg_Write_in, Mem_Read_in, Mem_Write_in, Mem_to_Reg_in, Reg_Dst_in;
  logic [1:0]  ALU_src;
  logic [2:0]  ALU_operation;
  logic [4:0]  Rs, dst_1, dst_2, fwd_mem_dst, fwd_wb_dst;
  logic [31:0] data_1, data_2, sh_in, fwd_mem_data, fwd_wb_data;
  logic        fwd_mem_we, fwd_wb_we;
  logic        ex_busy, Reg_Write_out, Mem_Read_out, Mem_Write_out, Mem_to_Reg_out, zero;
  logic [31:0] alu_result, store_data;
  logic [4:0]  dst_out;

  int n_cmp = 0;
  int n_bad = 0;
  int n;
  logic [31:0] prev_alu;

  ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .Reg_Write_in(Reg_Write_in), .Mem_Read_in(Mem_Read_in), .Mem_Write_in(Mem_Write_in),
    .Mem_to_Reg_in(Mem_to_Reg_in), .Reg_Dst_in(Reg_Dst_in),
    .ALU_src(ALU_src), .ALU_operation(ALU_operation),
    .Rs(Rs), .dst_1(dst_1), .dst_2(dst_2),
    .data_1(data_1), .data_2(data_2), .sh_in(sh_in),
    .fwd_mem_dst(fwd_mem_dst), .fwd_wb_dst(fwd_wb_dst),
    .fwd_mem_we(fwd_mem_we), .fwd_wb_we(fwd_wb_we),
    .fwd_mem_data(fwd_mem_data), .fwd_wb_data(fwd_wb_data),
    .ex_busy(ex_busy), .alu_result(alu_result), .store_data(store_data), .dst_out(dst_out),
    .Reg_Write_out(Reg_Write_out), .Mem_Read_out(Mem_Read_out),
    .Mem_Write_out(Mem_Write_out), .Mem_to_Reg_out(Mem_to_Reg_out), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    Reg_Write_in = 0; Mem_Read_in = 0; Mem_Write_in = 0; Mem_to_Reg_in = 0; Reg_Dst_in = 0;
    ALU_src = SRC_REG; ALU_operation = OP_ADD;
    Rs = 5'd1; dst_1 = 5'd2; dst_2 = 5'd0;
    data_1 = 0; data_2 = 0; sh_in = 0;
    fwd_mem_dst = 0; fwd_wb_dst = 0; fwd_mem_we = 0; fwd_wb_we = 0;
    fwd_mem_data = 0; fwd_wb_data = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    clr();
    #2;
    chk("rst_alu", alu_result, 32'd0);
    chk("rst_dst", {27'd0, dst_out}, 32'd0);
    chk("rst_busy", {31'd0, ex_busy}, 32'd0);
    chk("rst_regwr", {31'd0, Reg_Write_out}, 32'd0);

    // ADD on the first edge after release
    @(negedge clk); rst_n = 1'b1;
    ALU_operation = OP_ADD; data_1 = 5; data_2 = 7; Reg_Dst_in = 1; dst_2 = 9; Reg_Write_in = 1;
    tick();
    chk("add_res", alu_result, 32'd12);
    chk("add_dst", {27'd0, dst_out}, 32'd9);
    chk("add_zero", {31'd0, zero}, 32'd0);
    chk("add_regwr", {31'd0, Reg_Write_out}, 32'd1);
    chk("add_store", store_data, 32'd7);

    // SUB with MEM and WB both matching Rs: MEM wins
    clr(); ALU_operation = OP_SUB; Rs = 3; dst_1 = 4; data_1 = 1; data_2 = 20;
    fwd_mem_dst = 3; fwd_mem_we = 1; fwd_mem_data = 20;
    fwd_wb_dst = 3; fwd_wb_we = 1; fwd_wb_data = 99; Mem_Write_in = 1;
    tick();
    chk("sub_res", alu_result, 32'd0);
    chk("sub_zero", {31'd0, zero}, 32'd1);
    chk("sub_dst", {27'd0, dst_out}, 32'd4);
    chk("sub_memwr", {31'd0, Mem_Write_out}, 32'd1);

    // WB forward onto Rt feeds both ALU and store_data
    clr(); Rs = 1; data_1 = 10; dst_1 = 6; data_2 = 3;
    fwd_wb_dst = 6; fwd_wb_we = 1; fwd_wb_data = 100;
    tick();
    chk("fwdb_res", alu_result, 32'd110);
    chk("fwdb_store", store_data, 32'd100);

    clr(); ALU_operation = OP_SLT; data_1 = 32'hFFFF_FFFF; data_2 = 1;
    tick();
    chk("slt_res", alu_result, 32'd1);
    ALU_operation = OP_ADD;
    tick();
    chk("add_wrap", alu_result, 32'd0);
    chk("add_wrap_zero", {31'd0, zero}, 32'd1);

    clr(); ALU_src = SRC_UPPR; data_1 = 1; sh_in = 32'd3;
    tick();
    chk("upper_imm", alu_result, 32'h0003_0001);
    clr(); ALU_operation = OP_AND; ALU_src = SRC_IMM; data_1 = 32'hF0F0; sh_in = 32'hFF00;
    tick();
    chk("and_imm", alu_result, 32'h0000_F000);
    clr(); ALU_operation = OP_SUB; ALU_src = SRC_REG2; data_1 = 10; data_2 = 3; sh_in = 32'h55;
    tick();
    chk("src11_sub", alu_result, 32'd7);

    // Rs = 0 must not forward even when MEM writes r0
    clr(); ALU_operation = OP_OR; Rs = 0; data_1 = 0; data_2 = 4; Reg_Write_in = 1;
    fwd_mem_dst = 0; fwd_mem_we = 1; fwd_mem_data = 55;
    tick();
    chk("r0_nofwd", alu_result, 32'd4);

    // MUL: 33 busy cycles with bubbles, result on edge 34
    clr(); ALU_operation = OP_MUL; data_1 = 32'h0001_0003; data_2 = 32'h0002_0005;
    Reg_Write_in = 1; Reg_Dst_in = 1; dst_2 = 7;
    prev_alu = alu_result;
    #1;
    chk("mul1_busy_issue", {31'd0, ex_busy}, 32'd1);
    n = 0;
    while (ex_busy === 1'b1 && n < 60) begin
      n++;
      if (n > 1) begin
        chk("mul1_bubble_regwr", {31'd0, Reg_Write_out}, 32'd0);
        chk("mul1_bubble_alu", alu_result, prev_alu);
      end
      tick();
    end
    chk("mul1_busy_cycles", n, 32'd33);
    tick();
    chk("mul1_res", alu_result, 32'h000B_000F);
    chk("mul1_dst", {27'd0, dst_out}, 32'd7);
    chk("mul1_regwr", {31'd0, Reg_Write_out}, 32'd1);

    // Back-to-back MUL; inputs disturbed mid-multiply must be ignored
    clr(); ALU_operation = OP_MUL; data_1 = 7; data_2 = 6; dst_1 = 3; Reg_Write_in = 1;
    prev_alu = alu_result;
    #1;
    chk("mul2_busy_issue", {31'd0, ex_busy}, 32'd1);
    n = 0;
    while (ex_busy === 1'b1 && n < 60) begin
      n++;
      if (n == 5) begin data_1 = 1000; data_2 = 1000; dst_1 = 9; end
      tick();
    end
    chk("mul2_busy_cycles", n, 32'd33);
    chk("mul2_hold_alu", alu_result, prev_alu);
    tick();
    chk("mul2_res", alu_result, 32'd42);
    chk("mul2_dst", {27'd0, dst_out}, 32'd3);

    // Reset ten cycles into a MUL aborts it
    clr(); ALU_operation = OP_MUL; data_1 = 3; data_2 = 4; Reg_Write_in = 1;
    for (int i = 0; i < 10; i++) tick();
    chk("mul3_busy_mid", {31'd0, ex_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_alu", alu_result, 32'd0);
    chk("abort_busy", {31'd0, ex_busy}, 32'd0);
    chk("abort_regwr", {31'd0, Reg_Write_out}, 32'd0);
    chk("abort_dst", {27'd0, dst_out}, 32'd0);
    clr(); ALU_operation = OP_ADD; data_1 = 2; data_2 = 3; dst_1 = 5; Reg_Write_in = 1;
    @(negedge clk); rst_n = 1'b1;
    tick();
    chk("post_rst_add", alu_result, 32'd5);
    chk("post_rst_dst", {27'd0, dst_out}, 32'd5);
    chk("post_rst_regwr", {31'd0, Reg_Write_out}, 32'd1);
    chk("post_rst_busy", {31'd0, ex_busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-low reset: clk, rst_n.
REQ-002 Ports, clock and reset first:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- Reg_Write_in, Mem_Read_in, Mem_Write_in, Mem_to_Reg_in, Reg_Dst_in  in  1 each  ID/EX control bits
- ALU_src  in  2  00 = data_2, 01 = sh_in, 10 = {sh_in[15:0], 16'b0}
- ALU_operation  in  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 100 MUL, others ADD
- Rs, dst_1, dst_2  in  5 each  source Rs, Rt, Rd
- data_1, data_2, sh_in  in  32 each  register operands and sign-extended immediate
- fwd_mem_dst, fwd_wb_dst  in  5 each  EX/MEM and MEM/WB destination registers
- fwd_mem_we, fwd_wb_we  in  1 each  write enables of those stages
- fwd_mem_data, fwd_wb_data  in  32 each  forwarded values
- ex_busy  out  1  upstream hold request
- alu_result, store_data  out  32 each  EX/MEM register outputs
- dst_out  out  5  EX/MEM register output
- Reg_Write_out, Mem_Read_out, Mem_Write_out, Mem_to_Reg_out  out  1 each  EX/MEM register outputs
- zero  out  1  EX/MEM register output, set when alu_result == 0

Function
REQ-003 Operand A selection: fwd_mem_data when fwd_mem_we=1, fwd_mem_dst=Rs and Rs≠0; otherwise fwd_wb_data on the same test against the WB stage; otherwise data_1.
REQ-004 Forwarded B SHALL use the same priority against Rt (dst_1) and SHALL drive store_data.
REQ-005 ALU operand B SHALL come from forwarded B or from the immediate, as set by ALU_src; ALU_src = 11 SHALL select forwarded B.
REQ-006 Arithmetic SHALL be 32-bit modulo 2^32 with no overflow trap.
REQ-007 SLT SHALL be a signed compare producing 1 or 0.
REQ-008 Destination SHALL be dst_2 when Reg_Dst_in = 1, otherwise dst_1.
REQ-009 Single-cycle operations SHALL register all outputs on the next rising edge, with latency 1.
REQ-010 FSM states: IDLE, MUL, DONE.
- IDLE with MUL decoded: latch forwarded A and B, load counter to 0, go to MUL.
- MUL: one shift-add step per cycle; after step 31 (counter = 31), go to DONE.
- DONE: register the low 32 bits of the product with the latched control bits and destination, go to IDLE.
REQ-011 ex_busy SHALL be 1 combinationally in IDLE when MUL is decoded, and 1 throughout MUL; it SHALL be 0 in DONE and IDLE otherwise.
REQ-012 MUL latency SHALL be 34 cycles from issue to a valid EX/MEM output.
REQ-013 While ex_busy = 1, EX/MEM outputs SHALL carry a bubble: all control outputs 0, data outputs unchanged.
REQ-014 Upstream SHALL hold the ID/EX inputs while ex_busy = 1; the block SHALL ignore input changes during MUL.
REQ-015 A MUL issued on the cycle immediately after DONE SHALL start normally, with no extra bubble.
REQ-016 Forwarding from Rs or Rt = 0 SHALL never occur; register 0 always reads data_1 or data_2.

Reset
REQ-017 rst_n low SHALL immediately clear all outputs, the counter and the operand latches to 0, and set the FSM to IDLE.
REQ-018 Reset during MUL SHALL abort the multiply; no partial product SHALL be emitted.
REQ-019 The first edge after reset release SHALL process the inputs normally.

Structure
REQ-020 A shared package pipe_pkg SHALL hold:
- the ALU_operation encoding constants;
- the ALU_src encoding constants;
- the ex_state_t enumeration.
REQ-021 The iterative multiplier SHALL be a sub-module named seq_mul, with a start/busy/done handshake; ALU, forwarding and EX/MEM registers SHALL be local to ex_stage.

Verification
REQ-022 ADD, data_1 = 5, data_2 = 7, ALU_src = 00, Reg_Dst = 1, dst_2 = 9 -> next edge: alu_result = 12, dst_out = 9, zero = 0.
REQ-023 SUB with Rs = 3, fwd_mem_dst = 3, fwd_mem_we = 1, fwd_mem_data = 20, fwd_wb_dst = 3, fwd_wb_data = 99, data_2 = 20 -> alu_result = 0, zero = 1 (MEM has priority over WB).
REQ-024 SLT with A = 0xFFFFFFFF, B = 1 -> alu_result = 1; same operands with ADD -> alu_result = 0.
REQ-025 MUL with A = 0x00010003, B = 0x00020005 -> ex_busy high for 33 cycles, control outputs 0 meanwhile, then alu_result = 0x000B000F at cycle 34.
REQ-026 rst_n pulsed low at cycle 10 of a MUL -> outputs 0 at once, FSM IDLE, ex_busy = 0; a following ADD completes in 1 cycle.
REQ-027 Rs = 0 with fwd_mem_dst = 0, fwd_mem_we = 1, fwd_mem_data = 55, data_1 = 0, OR with B = 4 -> alu_result = 4.
